// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//
// Purpose:
//   Small circular write-back queue that sits between a producer of register
//   writes and a single register-file write port. Accepted writes are held
//   until the write port is free and then drained in FIFO order. Pending
//   values can be forwarded to two read-index queries, returning the youngest
//   pending value for a register. Writes to register 0 are accepted and
//   discarded.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   producer request valid
//   in_ready   queue has a free entry (registered-state decode only)
//   in_rd      destination register index of the request
//   in_data    data of the request
//   stall      register-file write port unavailable this cycle
//   write      register-file write enable (head entry popped on this edge)
//   rd         head entry register index (0 when empty)
//   writedata  head entry data (0 when empty)
//   rs1, rs2   forwarding query indices
//   fwdN_hit   some occupied entry targets rsN (never for rsN == 0)
//   fwdN_data  youngest pending value for rsN, else 0
//   count      number of occupied entries, 0..DEPTH
// -----------------------------------------------------------------------------
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_rd,
  input  logic [31:0]                in_data,
  input  logic                       stall,
  output logic                       write,
  output logic [4:0]                 rd,
  output logic [31:0]                writedata,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  output logic                       fwd1_hit,
  output logic [31:0]                fwd1_data,
  output logic                       fwd2_hit,
  output logic [31:0]                fwd2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // DEPTH must be a power of two so the pointers wrap naturally.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_write_queue: DEPTH must be a power of two and at least 2");
  end

  logic [4:0]       mem_rd   [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] fwd_idx;

  // Handshake and drain decode. in_ready looks only at registered count, so a
  // full queue never accepts even if it is popping on the same edge. A
  // request to register 0 completes the handshake but never takes an entry.
  always_comb begin
    in_ready  = (count != CNT_W'(DEPTH));
    push      = in_valid && in_ready && (in_rd != 5'd0);
    write     = (count != '0) && !stall;
    pop       = write;
    rd        = '0;
    writedata = '0;
    if (count != '0) begin
      rd        = mem_rd[head];
      writedata = mem_data[head];
    end
  end

  // Forwarding scans occupied entries from oldest (head) to youngest, so a
  // later match overrides an earlier one and the youngest value wins. The
  // head entry still counts while it is being written this cycle; the
  // incoming request does not, as it is not stored until the edge.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if ((rs1 != 5'd0) && (mem_rd[fwd_idx] == rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data[fwd_idx];
        end
        if ((rs2 != 5'd0) && (mem_rd[fwd_idx] == rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data[fwd_idx];
        end
      end
    end
  end

  // Entry storage: written at the tail on every push, cleared by reset so no
  // stale data survives into the next run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else if (push) begin
      mem_rd[tail]   <= in_rd;
      mem_data[tail] <= in_data;
    end
  end

  // Pointer and occupancy update. Push is gated by in_ready and pop by
  // count != 0, so count can neither overflow nor underflow; a simultaneous
  // push and pop moves both pointers and leaves count alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_write_queue
//
// Directed bench for wb_write_queue with DEPTH = 4. Each scenario task drives
// its own stimulus and compares outputs against hand-computed values. Inputs
// change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_write_queue;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        stall;
  logic        write;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  count;

  int errors;
  int checks;

  wb_write_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .stall     (stall),
    .write     (write),
    .rd        (rd),
    .writedata (writedata),
    .rs1       (rs1),
    .rs2       (rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    stall    = 1'b0;
    rs1      = '0;
    rs2      = '0;
    #12;
    checks++;
    if (write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %0b expected 0", write); end
    checks++;
    if (rd !== 5'd0 || writedata !== 32'd0) begin errors++; $display("[TB] FAIL reset_head: got rd=%0d data=%h expected 0/0", rd, writedata); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++;
    if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0 || fwd1_data !== 32'd0 || fwd2_data !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_fwd: got %0b/%h %0b/%h expected all 0", fwd1_hit, fwd1_data, fwd2_hit, fwd2_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_rd    = 5'd5;
    in_data  = 32'hDEADBEEF;
    stall    = 1'b0;
    tick();
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    #1;
    checks++;
    if (write !== 1'b1 || rd !== 5'd5 || writedata !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL single_write: got w=%0b rd=%0d data=%h expected 1/5/deadbeef", write, rd, writedata);
    end
    checks++;
    if (count !== 3'd1) begin errors++; $display("[TB] FAIL single_count1: got %0d expected 1", count); end
    tick();
    checks++;
    if (count !== 3'd0 || write !== 1'b0) begin
      errors++; $display("[TB] FAIL single_drained: got count=%0d w=%0b expected 0/0", count, write);
    end
  endtask

  task automatic test_fill();
    stall = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      in_valid = 1'b1;
      in_rd    = 5'(r);
      in_data  = 32'(r * 16);
      tick();
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_full: got count=%0d ready=%0b expected 4/0", count, in_ready);
    end
    checks++;
    if (write !== 1'b0) begin errors++; $display("[TB] FAIL fill_stalled: got w=%0b expected 0", write); end
    in_rd   = 5'd9;
    in_data = 32'h99;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_fifth_rejected: got count=%0d expected 4", count); end
    stall = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (write !== 1'b1 || rd !== 5'(k) || writedata !== 32'(k * 16)) begin
        errors++; $display("[TB] FAIL fill_drain_%0d: got w=%0b rd=%0d data=%h expected 1/%0d/%h", k, write, rd, writedata, k, k * 16);
      end
      tick();
    end
    checks++;
    if (count !== 3'd0 || write !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL fill_empty: got count=%0d w=%0b ready=%0b expected 0/0/1", count, write, in_ready);
    end
  endtask

  task automatic test_forward();
    stall    = 1'b1;
    rs1      = 5'd7;
    rs2      = 5'd0;
    in_valid = 1'b1;
    in_rd    = 5'd7;
    in_data  = 32'h11;
    #1;
    checks++;
    if (fwd1_hit !== 1'b0) begin errors++; $display("[TB] FAIL fwd_excludes_input: got %0b expected 0", fwd1_hit); end
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    #1;
    checks++;
    if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin
      errors++; $display("[TB] FAIL fwd_youngest: got %0b/%h expected 1/00000022", fwd1_hit, fwd1_data);
    end
    checks++;
    if (fwd2_hit !== 1'b0 || fwd2_data !== 32'd0) begin
      errors++; $display("[TB] FAIL fwd_rs_zero: got %0b/%h expected 0/0", fwd2_hit, fwd2_data);
    end
    rs2 = 5'd7;
    stall = 1'b0;
    #1;
    checks++;
    if (write !== 1'b1 || writedata !== 32'h11 || fwd2_hit !== 1'b1 || fwd2_data !== 32'h22) begin
      errors++; $display("[TB] FAIL fwd_drain_old: got w=%0b data=%h fwd2=%0b/%h expected 1/11/1/22", write, writedata, fwd2_hit, fwd2_data);
    end
    tick();
    checks++;
    if (write !== 1'b1 || writedata !== 32'h22 || fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin
      errors++; $display("[TB] FAIL fwd_drain_young: got w=%0b data=%h fwd1=%0b/%h expected 1/22/1/22", write, writedata, fwd1_hit, fwd1_data);
    end
    tick();
    checks++;
    if (fwd1_hit !== 1'b0 || fwd1_data !== 32'd0 || count !== 3'd0) begin
      errors++; $display("[TB] FAIL fwd_after_drain: got %0b/%h count=%0d expected 0/0/0", fwd1_hit, fwd1_data, count);
    end
    rs1 = '0;
    rs2 = '0;
  endtask

  task automatic test_rd_zero();
    stall    = 1'b0;
    in_valid = 1'b1;
    in_rd    = 5'd0;
    in_data  = 32'h1234;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd0_ready: got %0b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    checks++;
    if (count !== 3'd0 || write !== 1'b0) begin
      errors++; $display("[TB] FAIL rd0_not_queued: got count=%0d w=%0b expected 0/0", count, write);
    end
    tick();
    checks++;
    if (write !== 1'b0) begin errors++; $display("[TB] FAIL rd0_no_write: got %0b expected 0", write); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_q[$];
    logic [4:0] exp_rd;
    stall    = 1'b1;
    in_valid = 1'b1;
    for (int r = 1; r <= 2; r++) begin
      in_rd   = 5'(r);
      in_data = 32'hA0 + 32'(r);
      exp_q.push_back(5'(r));
      tick();
    end
    stall = 1'b0;
    for (int r = 3; r <= 8; r++) begin
      in_rd   = 5'(r);
      in_data = 32'hA0 + 32'(r);
      #1;
      exp_rd = exp_q[0];
      checks++;
      if (write !== 1'b1 || rd !== exp_rd || writedata !== (32'hA0 + 32'(exp_rd)) || count !== 3'd2) begin
        errors++; $display("[TB] FAIL b2b_step_%0d: got w=%0b rd=%0d data=%h count=%0d expected 1/%0d/%h/2", r, write, rd, writedata, count, exp_rd, 32'hA0 + 32'(exp_rd));
      end
      void'(exp_q.pop_front());
      exp_q.push_back(5'(r));
      tick();
    end
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    while (exp_q.size() > 0) begin
      #1;
      exp_rd = exp_q[0];
      checks++;
      if (write !== 1'b1 || rd !== exp_rd) begin
        errors++; $display("[TB] FAIL b2b_tail_%0d: got w=%0b rd=%0d expected 1/%0d", exp_rd, write, rd, exp_rd);
      end
      void'(exp_q.pop_front());
      tick();
    end
    checks++;
    if (count !== 3'd0) begin errors++; $display("[TB] FAIL b2b_empty: got count=%0d expected 0", count); end
  endtask

  task automatic test_reset_mid();
    stall    = 1'b1;
    in_valid = 1'b1;
    for (int r = 10; r <= 12; r++) begin
      in_rd   = 5'(r);
      in_data = 32'(r);
      tick();
    end
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    rs1      = 5'd10;
    #1;
    checks++;
    if (count !== 3'd3 || fwd1_hit !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_pre: got count=%0d hit=%0b expected 3/1", count, fwd1_hit);
    end
    #2;
    reset_n = 1'b0;
    stall   = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || write !== 1'b0 || fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_async: got count=%0d w=%0b hits=%0b%0b expected 0/0/00", count, write, fwd1_hit, fwd2_hit);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (write !== 1'b0 || count !== 3'd0) begin
        errors++; $display("[TB] FAIL midrst_idle_%0d: got w=%0b count=%0d expected 0/0", c, write, count);
      end
    end
    rs1 = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
